// File: rtl/fifo_pkg.sv
// Shared widths and FSM state encoding for the FIFO word unpacker.
// Used by fifo_unpacker and any block that talks to the same FIFO.
package fifo_pkg;

   localparam int WORD_W = 288;
   localparam int BEAT_W = 72;
   localparam int BEATS  = 4;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t WAIT = 2'd1;
   localparam state_t SEND = 2'd2;

endpackage

// File: rtl/fifo_par_gen.sv
// Even parity over one output beat, forced low when no beat is valid.
// Instantiated by fifo_unpacker only under FIFO_UNPACKER_PARITY_EN.
module fifo_par_gen #(
   parameter int W = 72
) (
   input  logic [W-1:0] data,
   input  logic         valid,
   output logic         par
);

   assign par = valid & (^data);

endmodule

// File: rtl/fifo_unpacker.sv
// Reads WORD_W words from a FIFO and emits them as BEATS beats, LSB first.
// Optional out_par output is enabled by defining FIFO_UNPACKER_PARITY_EN.
module fifo_unpacker
   import fifo_pkg::*;
#(
   parameter int WORD_W = fifo_pkg::WORD_W,
   parameter int BEAT_W = fifo_pkg::BEAT_W,
   parameter int BEATS  = fifo_pkg::BEATS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fifo_empty,
   output logic              read_en,
   input  logic [WORD_W-1:0] read_dt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BEAT_W-1:0] out_data,
   output logic              out_last
`ifdef FIFO_UNPACKER_PARITY_EN
   ,
   output logic              out_par
`endif
);

   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [WORD_W-1:0] hold;
   logic              run_q;
   logic              last_xfer;

   assign out_valid = (state == SEND);
   assign out_last  = out_valid && (idx == LAST_IDX);
   assign out_data  = out_valid ? hold[idx*BEAT_W +: BEAT_W] : '0;
   assign last_xfer = out_last && out_ready;

   // run_q keeps read_en low while reset is held with a non-empty FIFO
   assign read_en = run_q && !fifo_empty &&
                    ((state == IDLE) || last_xfer);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         state <= IDLE;
         idx   <= '0;
         hold  <= '0;
      end else begin
         run_q <= 1'b1;
         unique case (state)
            IDLE: begin
               if (read_en) state <= WAIT;
            end
            WAIT: begin
               hold  <= read_dt;
               idx   <= '0;
               state <= SEND;
            end
            SEND: begin
               if (out_ready) begin
                  if (out_last) state <= read_en ? WAIT : IDLE;
                  else          idx   <= idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FIFO_UNPACKER_PARITY_EN
   fifo_par_gen #(
      .W(BEAT_W)
   ) u_par (
      .data (out_data),
      .valid(out_valid),
      .par  (out_par)
   );
`endif

endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed self-checking bench for fifo_unpacker with a small FIFO model.
// Scenarios: reset, single word, back-to-back, backpressure, empty, reset.
module tb_fifo_unpacker;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         fifo_empty;
   logic         read_en;
   logic [287:0] read_dt = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [71:0]  out_data;
   logic         out_last;
`ifdef FIFO_UNPACKER_PARITY_EN
   logic         out_par;
`endif

   int checks = 0;
   int errors = 0;

   logic [287:0] mem [16];
   int wr_ptr = 0;
   int rd_ptr = 0;

   always #5 clk = ~clk;

   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (read_en) begin
         read_dt <= mem[rd_ptr % 16];
         rd_ptr  <= rd_ptr + 1;
      end
   end

   fifo_unpacker dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fifo_empty(fifo_empty),
      .read_en   (read_en),
      .read_dt   (read_dt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
`ifdef FIFO_UNPACKER_PARITY_EN
      ,
      .out_par   (out_par)
`endif
   );

   task automatic push(input logic [287:0] w);
      mem[wr_ptr % 16] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_rd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (read_en === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      out_ready = 1'b1;
      push(288'ha);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (read_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_read_en cyc=%0d got=%b exp=0", c, read_en);
         end
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid cyc=%0d got=%b exp=0", c, out_valid);
         end
         checks++;
         if (out_data !== 72'h0) begin
            errors++;
            $display("FAIL reset_data cyc=%0d got=%h exp=0", c, out_data);
         end
         checks++;
         if (out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_last cyc=%0d got=%b exp=0", c, out_last);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_word();
      bit ok;
      logic [71:0] exp;
      wait_rd(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_rd_timeout got=none exp=read_en");
         return;
      end
      for (int t = 1; t <= 6; t++) begin
         @(negedge clk);
         #1;
         checks++;
         if (read_en !== 1'b0) begin
            errors++;
            $display("FAIL single_read_en t=%0d got=%b exp=0", t, read_en);
         end
         checks++;
         if (out_valid !== (t >= 2 && t <= 5)) begin
            errors++;
            $display("FAIL single_valid t=%0d got=%b", t, out_valid);
         end
         if (t >= 2 && t <= 5) begin
            exp = (t == 2) ? 72'ha : 72'h0;
            checks++;
            if (out_data !== exp) begin
               errors++;
               $display("FAIL single_data t=%0d got=%h exp=%h",
                        t, out_data, exp);
            end
            checks++;
            if (out_last !== (t == 5)) begin
               errors++;
               $display("FAIL single_last t=%0d got=%b", t, out_last);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [71:0] bd [16];
      int bt [16];
      int nb = 0;
      logic [71:0] exp;
      push(288'ha);
      push(288'hb);
      push(288'hc);
      wait_rd(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_rd_timeout got=none exp=read_en");
         return;
      end
      for (int t = 1; t <= 15; t++) begin
         @(negedge clk);
         #1;
         checks++;
         if (read_en !== (t == 5 || t == 10)) begin
            errors++;
            $display("FAIL b2b_read_en t=%0d got=%b", t, read_en);
         end
         if (out_valid && out_ready && nb < 16) begin
            bd[nb] = out_data;
            bt[nb] = t;
            nb++;
         end
      end
      checks++;
      if (nb != 12) begin
         errors++;
         $display("FAIL b2b_count got=%0d exp=12", nb);
      end
      for (int i = 0; i < nb && i < 12; i++) begin
         exp = (i % 4 == 0) ? 72'(10 + i / 4) : 72'h0;
         checks++;
         if (bd[i] !== exp || bt[i] != 2 + 5 * (i / 4) + i % 4) begin
            errors++;
            $display("FAIL b2b_beat i=%0d got=%h@%0d exp=%h@%0d",
                     i, bd[i], bt[i], exp, 2 + 5 * (i / 4) + i % 4);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [71:0] rx [8];
      int nr = 0;
      push({72'h44, 72'h33, 72'h22, 72'h11});
      wait_rd(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_rd_timeout got=none exp=read_en");
         return;
      end
      for (int t = 1; t <= 11; t++) begin
         @(negedge clk);
         out_ready = !(t >= 3 && t <= 7);
         #1;
         if (t >= 3 && t <= 7) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 72'h22 ||
                out_last !== 1'b0) begin
               errors++;
               $display("FAIL bp_hold t=%0d got=%b/%h/%b exp=1/22/0",
                        t, out_valid, out_data, out_last);
            end
         end
         checks++;
         if (read_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_read_en t=%0d got=%b exp=0", t, read_en);
         end
         if (out_valid && out_ready && nr < 8) begin
            rx[nr] = out_data;
            nr++;
         end
      end
      out_ready = 1'b1;
      checks++;
      if (nr != 4) begin
         errors++;
         $display("FAIL bp_count got=%0d exp=4", nr);
      end
      for (int i = 0; i < nr && i < 4; i++) begin
         checks++;
         if (rx[i] !== 72'(8'h11 * (i + 1))) begin
            errors++;
            $display("FAIL bp_beat i=%0d got=%h exp=%h",
                     i, rx[i], 72'(8'h11 * (i + 1)));
         end
      end
   endtask

   task automatic test_empty_boundary();
      bit ok;
      int pulses = 0;
      push(288'ha);
      push(288'hb);
      wait_rd(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL empty_rd_timeout got=none exp=read_en");
         return;
      end
      for (int t = 1; t <= 14; t++) begin
         @(negedge clk);
         #1;
         if (t == 10) begin
            checks++;
            if (out_last !== 1'b1 || read_en !== 1'b0) begin
               errors++;
               $display("FAIL empty_last_beat got=%b/%b exp=last1/rd0",
                        out_last, read_en);
            end
         end else if (t > 10) begin
            checks++;
            if (out_valid !== 1'b0 || read_en !== 1'b0) begin
               errors++;
               $display("FAIL empty_idle t=%0d got=%b/%b exp=0/0",
                        t, out_valid, read_en);
            end
         end
      end
      push(288'hc);
      for (int t = 0; t < 10; t++) begin
         #1;
         if (read_en === 1'b1) pulses++;
         @(negedge clk);
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL empty_restart_pulses got=%0d exp=1", pulses);
      end
   endtask

   task automatic test_mid_word_reset();
      bit ok;
      bit hit = 1'b0;
      logic [71:0] rx [8];
      logic rl [8];
      int nr = 0;
      push({72'h44, 72'h33, 72'h22, 72'h11});
      wait_rd(ok);
      for (int t = 1; t <= 15 && !hit; t++) begin
         @(negedge clk);
         #1;
         if (out_valid && out_data == 72'h33) hit = 1'b1;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL mrst_no_beat3 got=none exp=33");
         return;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (read_en !== 1'b0 || out_valid !== 1'b0 ||
          out_data !== 72'h0 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL mrst_outputs got=%b/%b/%h/%b exp=0/0/0/0",
                  read_en, out_valid, out_data, out_last);
      end
`ifdef FIFO_UNPACKER_PARITY_EN
      checks++;
      if (out_par !== 1'b0) begin
         errors++;
         $display("FAIL mrst_par got=%b exp=0", out_par);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      push({72'h88, 72'h87, 72'h66, 72'h55});
      wait_rd(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL mrst_rd_timeout got=none exp=read_en");
         return;
      end
      for (int t = 1; t <= 8; t++) begin
         @(negedge clk);
         #1;
`ifdef FIFO_UNPACKER_PARITY_EN
         checks++;
         if (out_par !== (out_valid & (^out_data))) begin
            errors++;
            $display("FAIL mrst_par t=%0d got=%b exp=%b",
                     t, out_par, out_valid & (^out_data));
         end
`endif
         if (out_valid && out_ready && nr < 8) begin
            rx[nr] = out_data;
            rl[nr] = out_last;
            nr++;
         end
      end
      checks++;
      if (nr != 4) begin
         errors++;
         $display("FAIL mrst_count got=%0d exp=4", nr);
      end
      checks++;
      if (nr >= 4 && (rx[0] !== 72'h55 || rx[1] !== 72'h66 ||
          rx[2] !== 72'h87 || rx[3] !== 72'h88)) begin
         errors++;
         $display("FAIL mrst_data got=%h,%h,%h,%h exp=55,66,87,88",
                  rx[0], rx[1], rx[2], rx[3]);
      end
      checks++;
      if (nr >= 4 && (rl[0] || rl[1] || rl[2] || !rl[3])) begin
         errors++;
         $display("FAIL mrst_last got=%b%b%b%b exp=0001",
                  rl[0], rl[1], rl[2], rl[3]);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_empty_boundary();
      test_mid_word_reset();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_unpacker.md
FIFO_UNPACKER -- requirements
Module: fifo_unpacker

Interface
REQ-001 SHALL have parameter WORD_W, default 288, meaning the FIFO read word width (72*4).
REQ-002 SHALL have parameter BEAT_W, default 72, meaning the output beat width.
REQ-003 SHALL have parameter BEATS, default 4, meaning beats per word; WORD_W == BEAT_W*BEATS.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning the reset, asynchronous and active-low.
REQ-006 SHALL have port fifo_empty  input  1  meaning the FIFO holds no word.
REQ-007 SHALL have port read_en  output  1  meaning the FIFO read strobe; one word per high cycle.
REQ-008 SHALL have port read_dt  input  WORD_W  meaning the FIFO read data, valid the cycle after read_en.
REQ-009 SHALL have port out_valid  output  1  meaning out_data holds a beat.
REQ-010 SHALL have port out_ready  input  1  meaning the sink accepts the beat this cycle.
REQ-011 SHALL have port out_data  output  BEAT_W  meaning the current beat.
REQ-012 SHALL have port out_last  output  1  meaning the current beat is the final beat of a word.

Function
REQ-013 SHALL implement the states IDLE, WAIT and SEND.
REQ-014 In IDLE with fifo_empty=0, the block SHALL assert read_en for exactly one cycle and enter WAIT.
REQ-015 In WAIT, the block SHALL capture read_dt into a WORD_W hold register, set beat index to 0 and enter SEND.
REQ-016 In SEND, the block SHALL drive out_valid=1 and out_data=hold[idx*BEAT_W +: BEAT_W], sending the LSB beat first.
REQ-017 A beat SHALL transfer only on out_valid&&out_ready; idx increments by 1 per transfer.
REQ-018 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-019 out_last SHALL be 1 only when idx == BEATS-1 and out_valid=1.
REQ-020 On transfer of the last beat with fifo_empty=0, the block SHALL assert read_en in that same cycle and enter WAIT; with fifo_empty=1 it SHALL enter IDLE.
REQ-021 read_en SHALL never be asserted while fifo_empty=1 or while a word is in flight.
REQ-022 Sustained throughput SHALL be BEATS beats per BEATS+1 cycles, with one bubble cycle (the WAIT state) between words.
REQ-023 The idx counter SHALL wrap from BEATS-1 to 0 only through WAIT; it SHALL NOT wrap within SEND.

Reset
REQ-024 With rst_n=0, the block SHALL immediately force read_en=0, out_valid=0, out_data=0 and out_last=0, set the state to IDLE and idx to 0.
REQ-025 A reset asserted mid-word SHALL discard the hold register contents; after release the block SHALL restart from IDLE with no partial beat.

Configuration
REQ-026 With macro FIFO_UNPACKER_PARITY_EN defined, the block SHALL add output out_par (1 bit), equal to the XOR of out_data and valid with out_valid; it is 0 in reset.
REQ-027 Without FIFO_UNPACKER_PARITY_EN defined, out_par and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-028 Package fifo_pkg SHALL hold WORD_W, BEAT_W and BEATS, plus the state typedef (IDLE/WAIT/SEND), all shared with FIFO.
REQ-029 The parity logic SHALL be the sub-module fifo_par_gen, instantiated only under FIFO_UNPACKER_PARITY_EN; all other logic SHALL reside in fifo_unpacker.

Verification
REQ-030 Reset test: hold rst_n=0 with fifo_empty=0 -> read_en, out_valid, out_data and out_last all remain 0.
REQ-031 Single word test: FIFO holds 'ha and out_ready=1 -> read_en is high for 1 cycle, then beats 'ha, 0, 0, 0 appear on consecutive cycles with out_last on beat 4, then the block returns to IDLE.
REQ-032 Back-to-back test: FIFO holds 'ha, 'hb, 'hc and out_ready=1 -> 12 beats in 15 cycles after the first read_en, with one bubble between words and in-order data.
REQ-033 Backpressure test: out_ready=0 for 5 cycles during beat 2 -> out_data holds stable, no beat is lost or duplicated, and read_en stays 0.
REQ-034 Empty boundary test: fifo_empty goes to 1 as the last beat of 'hb transfers -> no read_en pulse and the block enters IDLE; fifo_empty then goes to 0 -> a single read_en pulse follows.
REQ-035 Mid-word reset test: rst_n pulses low during beat 3 -> outputs are 0 immediately; after release, the next word starts at beat 0; with FIFO_UNPACKER_PARITY_EN defined, out_par matches the XOR of out_data on every beat.
